// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared downstream memory bus of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if;
    logic        p0_valid;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_wstrb;
    logic        p0_ready;
    logic        p0_err;

    logic        p1_valid;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_wstrb;
    logic        p1_ready;
    logic        p1_err;

    logic [31:0] p_rdata;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_valid, p0_addr, p0_wdata, p0_wstrb,
        input  p1_valid, p1_addr, p1_wdata, p1_wstrb,
        input  mem_ready, mem_rdata,
        output p0_ready, p0_err, p1_ready, p1_err, p_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output p0_valid, p0_addr, p0_wdata, p0_wstrb,
        output p1_valid, p1_addr, p1_wdata, p1_wstrb,
        output mem_ready, mem_rdata,
        input  p0_ready, p0_err, p1_ready, p1_err, p_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (port 1 = load/store, port 0 = fetch) with a watchdog timeout.
// Define MEM_ARBITER_RR_EN for round-robin priority instead of fixed port-1-first.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t      state, next_state;
    logic [15:0] wd_cnt, next_cnt;
    logic        gnt0, gnt1;
    logic        sel_en, sel1;
    logic        done0, done1, timeout, abort;
    logic        busy_valid;

`ifdef MEM_ARBITER_RR_EN
    // rr_ptr = 1 means port 1 wins a tie; it flips only on completions, never on aborts.
    logic rr_ptr;

    always_comb begin
        gnt1 = bus.p1_valid && (!bus.p0_valid || rr_ptr);
        gnt0 = bus.p0_valid && (!bus.p1_valid || !rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst)        rr_ptr <= 1'b1;
        else if (done1) rr_ptr <= 1'b0;
        else if (done0) rr_ptr <= 1'b1;
    end
`else
    always_comb begin
        gnt1 = bus.p1_valid;
        gnt0 = bus.p0_valid && !bus.p1_valid;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wd_cnt <= 16'd0;
        end else begin
            state  <= next_state;
            wd_cnt <= next_cnt;
        end
    end

    assign busy_valid = (state == BUSY1) ? bus.p1_valid : bus.p0_valid;

    // Abort takes precedence over everything, and mem_ready beats a coincident timeout.
    always_comb begin
        next_state = state;
        next_cnt   = wd_cnt;
        sel_en     = 1'b0;
        sel1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        timeout    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt1 || gnt0) begin
                    sel_en = 1'b1;
                    sel1   = gnt1;
                    if (bus.mem_ready) begin
                        done1 = gnt1;
                        done0 = gnt0;
                    end else begin
                        next_state = gnt1 ? BUSY1 : BUSY0;
                        next_cnt   = 16'd1;
                    end
                end
            end
            BUSY0, BUSY1: begin
                sel_en = 1'b1;
                sel1   = (state == BUSY1);
                if (!busy_valid) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                    next_cnt   = 16'd0;
                end else if (bus.mem_ready || wd_cnt == 16'(TIMEOUT)) begin
                    timeout    = !bus.mem_ready;
                    done1      = (state == BUSY1);
                    done0      = (state == BUSY0);
                    next_state = IDLE;
                    next_cnt   = 16'd0;
                end else begin
                    next_cnt = wd_cnt + 16'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 16'd0;
            end
        endcase
    end

    // The reset cycle forces every handshake output low whatever the inputs are doing.
    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
        if (sel_en) begin
            if (sel1) begin
                bus.mem_valid = bus.p1_valid;
                bus.mem_addr  = bus.p1_addr;
                bus.mem_wdata = bus.p1_wdata;
                bus.mem_wstrb = bus.p1_wstrb;
            end else begin
                bus.mem_valid = bus.p0_valid;
                bus.mem_addr  = bus.p0_addr;
                bus.mem_wdata = bus.p0_wdata;
                bus.mem_wstrb = bus.p0_wstrb;
            end
        end
        if (timeout || abort || rst) bus.mem_valid = 1'b0;
        if (abort || rst)            bus.mem_wstrb = 4'd0;
        bus.p0_ready = done0 && !rst;
        bus.p1_ready = done1 && !rst;
        bus.p0_err   = done0 && timeout && !rst;
        bus.p1_err   = done1 && timeout && !rst;
        bus.p_rdata  = timeout ? 32'd0 : bus.mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with TIMEOUT = 4.
// Tie-break expectations follow MEM_ARBITER_RR_EN when the bench is built with it.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                                input logic v1, input logic [31:0] a1, input logic [3:0] s1,
                                input logic mr, input logic [31:0] rd);
      bus.p0_valid  = v0;
      bus.p0_addr   = a0;
      bus.p0_wdata  = 32'h1111_0000;
      bus.p0_wstrb  = 4'h0;
      bus.p1_valid  = v1;
      bus.p1_addr   = a1;
      bus.p1_wdata  = 32'hCAFE_0001;
      bus.p1_wstrb  = s1;
      bus.mem_ready = mr;
      bus.mem_rdata = rd;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;

      // Reset with a live request and mem_ready: nothing may leak out
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 4'h3, 1'b1, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      checkOutput("rst_p1_ready",  32'(bus.p1_ready),  32'd0);
      checkOutput("rst_p1_err",    32'(bus.p1_err),    32'd0);

      // Idle bus, stray mem_ready ignored
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h9999);
      checkOutput("idle_mem_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("idle_mem_addr",  bus.mem_addr,       32'd0);
      checkOutput("idle_mem_wdata", bus.mem_wdata,      32'd0);
      checkOutput("idle_readys",    32'({bus.p1_ready, bus.p0_ready}), 32'd0);
      nextCycle();

      // Both valid, immediate mem_ready: port 1 first, then port 0 once p1 drops
      applyStimulus(1'b1, 32'h200, 1'b1, 32'h100, 4'h0, 1'b1, 32'h1234);
      checkOutput("both_mem_addr", bus.mem_addr, 32'h100);
      checkOutput("both_p1_ready", 32'(bus.p1_ready), 32'd1);
      checkOutput("both_p0_ready", 32'(bus.p0_ready), 32'd0);
      checkOutput("both_p_rdata",  bus.p_rdata, 32'h1234);
      nextCycle();
      applyStimulus(1'b1, 32'h200, 1'b0, 32'h100, 4'h0, 1'b1, 32'h1234);
      checkOutput("p0only_mem_addr", bus.mem_addr, 32'h200);
      checkOutput("p0only_p0_ready", 32'(bus.p0_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      nextCycle();

      // p0 read held for 3 wait cycles while p1 arrives and must wait
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h300, 4'h0, 1'b0, 32'h0);
      checkOutput("p0rd_c0_addr",  bus.mem_addr, 32'h40);
      checkOutput("p0rd_c0_valid", 32'(bus.mem_valid), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h300, 4'h0, 1'b0, 32'h0);
      for (int i = 1; i < 3; i++) begin
         checkOutput("p0rd_wait_addr",     bus.mem_addr, 32'h40);
         checkOutput("p0rd_wait_p1_ready", 32'(bus.p1_ready), 32'd0);
         nextCycle();
      end
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h300, 4'h0, 1'b1, 32'hDEADBEEF);
      checkOutput("p0rd_c3_addr",     bus.mem_addr, 32'h40);
      checkOutput("p0rd_c3_p0_ready", 32'(bus.p0_ready), 32'd1);
      checkOutput("p0rd_c3_p1_ready", 32'(bus.p1_ready), 32'd0);
      checkOutput("p0rd_c3_p_rdata",  bus.p_rdata, 32'hDEADBEEF);
      nextCycle();
      applyStimulus(1'b0, 32'h40, 1'b1, 32'h300, 4'h0, 1'b1, 32'h0);
      checkOutput("p1_after_addr",  bus.mem_addr, 32'h300);
      checkOutput("p1_after_ready", 32'(bus.p1_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      nextCycle();

      // p1 store never answered: watchdog completes it 4 cycles after grant
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h500, 4'hF, 1'b0, 32'h5555);
      checkOutput("to_c0_wstrb", 32'(bus.mem_wstrb), 32'hF);
      checkOutput("to_c0_wdata", bus.mem_wdata, 32'hCAFE0001);
      for (int i = 1; i < 4; i++) begin
         nextCycle();
         checkOutput("to_wait_ready", 32'(bus.p1_ready), 32'd0);
         checkOutput("to_wait_err",   32'(bus.p1_err),   32'd0);
      end
      nextCycle();
      checkOutput("to_c4_ready",     32'(bus.p1_ready),  32'd1);
      checkOutput("to_c4_err",       32'(bus.p1_err),    32'd1);
      checkOutput("to_c4_p_rdata",   bus.p_rdata,        32'd0);
      checkOutput("to_c4_mem_valid", 32'(bus.mem_valid), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      checkOutput("to_idle_mem_valid", 32'(bus.mem_valid), 32'd0);
      nextCycle();

      // mem_ready in the same cycle as the timeout: normal completion
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h600, 4'h1, 1'b0, 32'h0);
      for (int i = 1; i < 4; i++) nextCycle();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h600, 4'h1, 1'b1, 32'h77);
      checkOutput("race_ready",   32'(bus.p1_ready), 32'd1);
      checkOutput("race_err",     32'(bus.p1_err),   32'd0);
      checkOutput("race_p_rdata", bus.p_rdata,       32'h77);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      nextCycle();

      // p1 aborts in BUSY1 while mem_ready arrives: discarded
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h700, 4'h5, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h700, 4'h5, 1'b1, 32'h0);
      checkOutput("abort_mem_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("abort_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      checkOutput("abort_p1_ready",  32'(bus.p1_ready),  32'd0);
      nextCycle();
      applyStimulus(1'b1, 32'h800, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0);
      checkOutput("abort_idle_addr",  bus.mem_addr, 32'h800);
      checkOutput("abort_idle_ready", 32'(bus.p0_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      nextCycle();

      // Reset during BUSY0 abandons silently; grant possible right after
      applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      nextCycle();
      rst = 1'b1;
      applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0);
      checkOutput("busyrst_mem_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("busyrst_p0_ready",  32'(bus.p0_ready),  32'd0);
      checkOutput("busyrst_p0_err",    32'(bus.p0_err),    32'd0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0);
      checkOutput("postrst_mem_valid", 32'(bus.mem_valid), 32'd1);
      checkOutput("postrst_p0_ready",  32'(bus.p0_ready),  32'd1);
      nextCycle();

      // Both ports always valid, mem_ready always high: tie-break pattern
      applyStimulus(1'b1, 32'hA00, 1'b1, 32'hB00, 4'h0, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_RR_EN
         checkOutput("tie_p1_ready", 32'(bus.p1_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("tie_p0_ready", 32'(bus.p0_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
`else
         checkOutput("tie_p1_ready", 32'(bus.p1_ready), 32'd1);
         checkOutput("tie_p0_ready", 32'(bus.p0_ready), 32'd0);
`endif
         nextCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
